// File: rtl/serial_to_parallel_reg.sv
// MSB-first bit-serial receiver: assembles WIDTH-bit words and hands them to a
// parallel consumer through a single holding register with valid/ready.
module serial_to_parallel_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic             overrun_q;

    logic             last_bit;
    logic             ready;
    logic             accept;
    logic             complete;
    logic             consume;
    logic [WIDTH-1:0] next_word;

    always_comb begin
        last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
        // Stall only when the incoming bit would finish a word with nowhere to go.
        ready     = !(last_bit && out_valid_q && !out_ready);
        accept    = sin_valid && ready && !flush;
        complete  = accept && last_bit;
        consume   = out_valid_q && out_ready;
        next_word = {shift_q[WIDTH-2:0], sin};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (sin_valid && !ready)
                overrun_q <= 1'b1;

            if (flush) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (accept) begin
                shift_q <= next_word;
                cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
            end

            // A completion in the same cycle as a consume reloads without a bubble.
            if (complete) begin
                out_q       <= next_word;
                out_valid_q <= 1'b1;
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign sin_ready = ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign bit_count = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_reg.sv
// Directed bench for serial_to_parallel_reg: word assembly, stall, overrun,
// flush, asynchronous reset and back-to-back completion.
module tb_serial_to_parallel_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        sin;
    logic        sin_valid;
    logic        sin_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  bit_count;
    logic        overrun;

    int unsigned total;
    int unsigned bad;

    serial_to_parallel_reg #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends the top nbits of w, MSB first; every bit here is expected to be accepted.
    task automatic feed(input logic [31:0] w, input int unsigned nbits, input logic rdy,
                        input logic hold_valid);
        for (int unsigned i = 0; i < nbits; i++) begin
            sin       = w[31 - i];
            sin_valid = 1'b1;
            out_ready = rdy;
            #1;
            check("feed_sin_ready", 64'(sin_ready), 64'd1);
            step();
            if (hold_valid)
                check("feed_out_valid_held", 64'(out_valid), 64'd1);
        end
        sin_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out",       64'(out),       64'h0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bit_count", 64'(bit_count), 64'd0);
        check("rst_overrun",   64'(overrun),   64'd0);
        reset = 1'b1;
        #10;
        step();

        // Plain word, consumer always ready
        feed(32'hA5C3_0F81, 31, 1'b1, 1'b0);
        check("w1_not_yet_valid", 64'(out_valid), 64'd0);
        check("w1_count31",       64'(bit_count), 64'd31);
        sin = 1'b1; sin_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("w1_last_ready", 64'(sin_ready), 64'd1);
        step();
        sin_valid = 1'b0;
        check("w1_out",       64'(out),       64'hA5C30F81);
        check("w1_out_valid", 64'(out_valid), 64'd1);
        check("w1_count0",    64'(bit_count), 64'd0);
        step();
        check("w1_consumed", 64'(out_valid), 64'd0);

        // Back-to-back words with consumer stalled
        feed(32'hFFFF_FFFF, 32, 1'b0, 1'b0);
        check("w2_out",       64'(out),       64'hFFFFFFFF);
        check("w2_out_valid", 64'(out_valid), 64'd1);
        feed(32'h0000_0001, 31, 1'b0, 1'b1);
        check("w3_count31", 64'(bit_count), 64'd31);
        check("w3_stall",   64'(sin_ready), 64'd0);
        sin = 1'b1; sin_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("w3_unstall", 64'(sin_ready), 64'd1);
        step();
        sin_valid = 1'b0;
        check("w3_out",       64'(out),       64'h00000001);
        check("w3_out_valid", 64'(out_valid), 64'd1);
        check("w3_no_overrun", 64'(overrun),  64'd0);
        step();
        check("w3_consumed", 64'(out_valid), 64'd0);

        // Stall with bits offered anyway -> overrun, bits dropped
        feed(32'h0F0F_0F0F, 32, 1'b0, 1'b0);
        feed(32'h1357_9BDF, 31, 1'b0, 1'b1);
        for (int unsigned k = 0; k < 3; k++) begin
            sin = k[0]; sin_valid = 1'b1; out_ready = 1'b0;
            #1;
            check("ov_stall", 64'(sin_ready), 64'd0);
            step();
            check("ov_flag",  64'(overrun),   64'd1);
            check("ov_count", 64'(bit_count), 64'd31);
            check("ov_out",   64'(out),       64'h0F0F0F0F);
        end
        sin = 1'b1; sin_valid = 1'b1; out_ready = 1'b1;
        step();
        sin_valid = 1'b0;
        check("ov_resume_out", 64'(out),       64'h13579BDF);
        check("ov_resume_vld", 64'(out_valid), 64'd1);
        check("ov_sticky",     64'(overrun),   64'd1);
        step();
        check("ov_consumed",   64'(out_valid), 64'd0);
        check("ov_out_kept",   64'(out),       64'h13579BDF);

        // Flush drops the partial word and the bit offered with it
        feed(32'hFFC0_0000, 10, 1'b1, 1'b0);
        check("fl_count10", 64'(bit_count), 64'd10);
        flush = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        step();
        flush = 1'b0; sin_valid = 1'b0;
        check("fl_count0", 64'(bit_count), 64'd0);
        feed(32'h1234_5678, 32, 1'b0, 1'b0);
        check("fl_out",       64'(out),       64'h12345678);
        check("fl_out_valid", 64'(out_valid), 64'd1);
        feed(32'hF800_0000, 5, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl2_count0",    64'(bit_count), 64'd0);
        check("fl2_out_valid", 64'(out_valid), 64'd1);
        check("fl2_out",       64'(out),       64'h12345678);

        // Asynchronous reset mid-word with a word pending
        feed(32'hFFFF_F000, 20, 1'b0, 1'b1);
        check("ar_count20", 64'(bit_count), 64'd20);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out",       64'(out),       64'h0);
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_count",     64'(bit_count), 64'd0);
        check("ar_overrun",   64'(overrun),   64'd0);
        #3;
        reset = 1'b1;
        step();
        feed(32'hDEAD_BEEF, 32, 1'b0, 1'b0);
        check("ar_new_out",   64'(out),       64'hDEADBEEF);
        check("ar_new_valid", 64'(out_valid), 64'd1);

        // Completion on the same edge as a consume: no bubble
        feed(32'h8000_0000, 31, 1'b0, 1'b1);
        check("bb_out_hold", 64'(out), 64'hDEADBEEF);
        sin = 1'b0; sin_valid = 1'b1; out_ready = 1'b1;
        step();
        sin_valid = 1'b0;
        check("bb_out",       64'(out),       64'h80000000);
        check("bb_out_valid", 64'(out_valid), 64'd1);
        step();
        check("bb_consumed", 64'(out_valid), 64'd0);
        check("bb_out_kept", 64'(out),       64'h80000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_reg.md
Name: serial_to_parallel_reg

Overview:
- Receive side of the MSB-first bit-serial link used by the sequential comparator datapath; the inverse of the parallel-load, left-shift serializer.
- Accepts one bit per accepted cycle and assembles WIDTH-bit words, MSB first.
- Presents each completed word in a holding register with a valid/ready handshake.
- Sits between the serial bit stream and any parallel consumer, such as result capture or loopback checking.

Parameters:
- WIDTH, 32, word width in bits; legal range 2..64.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- flush  input  1  synchronous clear of the partial word; does not touch the holding register.
- sin  input  1  serial data bit, MSB of each word first.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_ready  output  1  block can accept a bit this cycle.
- out  output  WIDTH  completed word from the holding register.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  consumer accepts out this cycle.
- bit_count  output  CNT_W  number of bits currently in the partial word, 0..WIDTH-1.
- overrun  output  1  sticky flag: sin_valid was asserted while sin_ready was low.

Behaviour:
- Reset (reset=0, asynchronous):
  - shift register = 0, bit_count = 0.
  - out = 0, out_valid = 0, overrun = 0.
  - sin_ready is 1 while reset is deasserted and no stall condition holds.
- Accept: a bit is accepted when sin_valid && sin_ready at the rising edge.
  - shift <= {shift[WIDTH-2:0], sin}.
  - bit_count <= bit_count+1.
- Word completion:
  - Occurs when an accept happens with bit_count == WIDTH-1.
  - out <= {shift[WIDTH-2:0], sin}, out_valid <= 1, bit_count <= 0, all on the same edge.
  - Latency: the final bit is visible on out one cycle after it is accepted.
- Consume: when out_valid && out_ready at the edge, out_valid <= 0.
  - out keeps its last value; it is not cleared.
- Simultaneous consume and completion in the same cycle: the new word loads and out_valid stays 1; no bubble.
- sin_ready (combinational) = !(bit_count == WIDTH-1 && out_valid && !out_ready).
  - The block stalls only when the next bit would complete a word that has nowhere to go.
- Overrun:
  - overrun <= 1 on any edge where sin_valid && !sin_ready.
  - The offered bit is dropped; shift and bit_count are unchanged.
  - overrun is cleared only by reset.
- flush=1 at the edge:
  - bit_count <= 0 and shift <= 0.
  - Any accept in that cycle is ignored.
  - flush has priority over accept and completion.
  - out and out_valid are unaffected; a consume in that cycle still applies.
- sin_valid=0: no state change except consume.
- Reset asserted mid-word or mid-handshake: the partial word and any pending output are discarded with no recovery.
- Counter wrap: bit_count never exceeds WIDTH-1; it returns to 0 only on completion, flush or reset.

Test Plan:
- Reset then feed 32 bits of 0xA5C3_0F81, MSB first, sin_valid=1 continuously, out_ready=1 -> out=0xA5C30F81 with out_valid=1 exactly one cycle after the 32nd bit; bit_count=0 at that point; sin_ready stays 1 throughout.
- Feed two back-to-back words 0xFFFF_FFFF then 0x0000_0001 with out_ready=0 -> after word 1, out_valid=1 and bit_count climbs to 31; sin_ready=0 with bit_count=31; raising out_ready for one cycle makes sin_ready=1; the next accept gives out=0x00000001 and out_valid remains 1.
- Same stall as the previous scenario, but hold sin_valid=1 while sin_ready=0 for 3 cycles -> overrun=1 and stays set; bit_count stays 31; the resumed word is correct.
- Feed 10 bits, pulse flush together with sin_valid=1, then feed 0x1234_5678 -> flushed bit not counted; bit_count=0 after flush; out=0x12345678 on completion.
- Feed 20 bits, then drive reset=0 between clock edges -> out, out_valid, bit_count and overrun go to 0 immediately without waiting for a clock edge; after release, a fresh word 0xDEAD_BEEF assembles correctly.
- Set out_valid=1 and hold out_ready=1 on the same edge as the 32nd bit of 0x8000_0000 -> out updates to 0x80000000 and out_valid does not drop for any cycle.
